// File: rtl/joy_cond_pkg.sv
// Shared constants, coin FSM state encoding and small helpers for the joystick conditioner.
package joy_cond_pkg;

    localparam int JB_UP    = 0;
    localparam int JB_DOWN  = 1;
    localparam int JB_LEFT  = 2;
    localparam int JB_RIGHT = 3;
    localparam int JB_FIRE1 = 4;
    localparam int JB_FIRE2 = 5;
    localparam int JB_FIRE3 = 6;
    localparam int JB_START = 7;

    typedef enum logic [1:0] {IDLE, ARM, PULSE, WAIT_REL} coin_state_t;

    // Bits needed to count 0..n-1 (never less than one).
    function automatic int timer_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Opposing directions held together cancel to "neither pressed" (active-low).
    function automatic logic [7:0] socd_clean(input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (!d[JB_UP] && !d[JB_DOWN]) begin
            r[JB_UP]   = 1'b1;
            r[JB_DOWN] = 1'b1;
        end
        if (!d[JB_LEFT] && !d[JB_RIGHT]) begin
            r[JB_LEFT]  = 1'b1;
            r[JB_RIGHT] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/joy_coin_fsm.sv
// Per-player coin synthesizer: a long start+fire1 hold yields one fixed-length active-low coin pulse.
module joy_coin_fsm
    import joy_cond_pkg::*;
#(
    parameter int HOLD_TICKS  = 500,
    parameter int PULSE_TICKS = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic start_n,
    input  logic fire1_n,
    output logic coin_n,
    output logic mask
);

    localparam int TW = (timer_w(HOLD_TICKS) > timer_w(PULSE_TICKS)) ?
                        timer_w(HOLD_TICKS) : timer_w(PULSE_TICKS);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_TICKS - 1);

    coin_state_t   state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          combo;

    assign combo = !start_n && !fire1_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            coin_n <= 1'b1;
            mask   <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            // Outputs registered from the next state so they align with the state register.
            coin_n <= (state_nxt != PULSE);
            mask   <= (state_nxt == PULSE) || (state_nxt == WAIT_REL);
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        unique case (state)
            IDLE: begin
                timer_nxt = '0;
                if (combo) state_nxt = ARM;
            end
            ARM: begin
                if (!combo) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (tick) begin
                    if (timer == HOLD_LAST) begin
                        state_nxt = PULSE;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end
            PULSE: begin
                if (tick) begin
                    if (timer == PULSE_LAST) begin
                        state_nxt = WAIT_REL;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end
            WAIT_REL: begin
                timer_nxt = '0;
                if (start_n && fire1_n) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/joy_conditioner.sv
// Resync, debounce and coin synthesis for two 8-button active-low joysticks.
// Build option JOY_SOCD_EN: cancel simultaneous opposite directions after debounce.
module joy_conditioner
    import joy_cond_pkg::*;
#(
    parameter int TICK_DIV         = 1389,
    parameter int DEBOUNCE_TICKS   = 4,
    parameter int COIN_HOLD_TICKS  = 500,
    parameter int COIN_PULSE_TICKS = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] joy1_raw,
    input  logic [7:0] joy2_raw,
    output logic [7:0] joy1_out,
    output logic [7:0] joy2_out,
    output logic       coin1_n,
    output logic       coin2_n,
    output logic       tick
);

    localparam int PW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [7:0]    MASK_BITS = (8'h1 << JB_START) | (8'h1 << JB_FIRE1);

    logic [PW-1:0] pre;
    logic [15:0]   raw, sync1, s, d, cond, out_q;
    logic [1:0]    coin_n, mask;

    assign raw  = {joy2_raw, joy1_raw};
    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset)     pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            s     <= '1;
            out_q <= '1;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            out_q <= cond;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          d_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
                d_q <= 1'b1;
            end else if (tick) begin
                if (s[i] == d_q) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    d_q <= s[i];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
        assign d[i] = d_q;
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
`ifdef JOY_SOCD_EN
        assign cond[p*8 +: 8] = socd_clean(d[p*8 +: 8]);
`else
        assign cond[p*8 +: 8] = d[p*8 +: 8];
`endif
        joy_coin_fsm #(
            .HOLD_TICKS  (COIN_HOLD_TICKS),
            .PULSE_TICKS (COIN_PULSE_TICKS)
        ) u_coin (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .start_n (d[p*8 + JB_START]),
            .fire1_n (d[p*8 + JB_FIRE1]),
            .coin_n  (coin_n[p]),
            .mask    (mask[p])
        );
    end

    // Masking keeps the coin combo from also registering as a game start.
    assign joy1_out = out_q[7:0]  | ({8{mask[0]}} & MASK_BITS);
    assign joy2_out = out_q[15:8] | ({8{mask[1]}} & MASK_BITS);
    assign coin1_n  = coin_n[0];
    assign coin2_n  = coin_n[1];

endmodule

// File: tb/tb_joy_conditioner.sv
// Directed bench for joy_conditioner with small timing parameters.
module tb_joy_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] joy1_raw, joy2_raw;
    logic [7:0] joy1_out, joy2_out;
    logic       coin1_n, coin2_n, tick;

    int n_asrt = 0;
    int n_fail = 0;

    joy_conditioner #(
        .TICK_DIV         (4),
        .DEBOUNCE_TICKS   (3),
        .COIN_HOLD_TICKS  (10),
        .COIN_PULSE_TICKS (5)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .joy1_raw (joy1_raw),
        .joy2_raw (joy2_raw),
        .joy1_out (joy1_out),
        .joy2_out (joy2_out),
        .coin1_n  (coin1_n),
        .coin2_n  (coin2_n),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_coin(input int p, input int bound, output int w);
        w = -1;
        for (int i = 1; i <= bound; i++) begin
            step(1);
            if (((p == 1) ? coin1_n : coin2_n) == 1'b0) begin
                w = i;
                return;
            end
        end
    endtask

    task automatic wait_out(input int p, input logic [7:0] v, input int bound, output int w);
        w = -1;
        for (int i = 1; i <= bound; i++) begin
            step(1);
            if (((p == 1) ? joy1_out : joy2_out) === v) begin
                w = i;
                return;
            end
        end
    endtask

    // Called with the coin already observed low; returns total low cycles.
    task automatic pulse_len(input int p, input int bound, output int len);
        len = 1;
        for (int i = 0; i < bound; i++) begin
            step(1);
            if (((p == 1) ? coin1_n : coin2_n) == 1'b1) return;
            len++;
        end
    endtask

    initial begin
        int  w, len, k;
        bit  seen;

        // Reset values
        reset = 1'b1; joy1_raw = 8'h00; joy2_raw = 8'h00;
        step(2);
        chk("rst_joy1", 16'(joy1_out), 16'hFF);
        chk("rst_joy2", 16'(joy2_out), 16'hFF);
        chk("rst_coin", 16'({coin1_n, coin2_n}), 16'h3);
        chk("rst_tick", 16'(tick), 16'h0);
        joy1_raw = 8'hFF; joy2_raw = 8'hFF; reset = 1'b0;

        // Prescaler: first tick three samples after release, then every 4th cycle
        k = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (tick) begin k = i; break; end
        end
        chk("tick_first", 16'(k), 16'd3);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("tick_period", 16'(tick), 16'((i % 4) == 0));
        end

        // Debounce of a held press
        joy1_raw = 8'hFE;
        wait_out(1, 8'hFE, 20, w);
        chk("db_lat_in_window", 16'((w >= 12) && (w <= 15)), 16'h1);
        chk("db_press_val", 16'(joy1_out), 16'hFE);
        joy1_raw = 8'hFF;
        step(20);
        chk("db_release", 16'(joy1_out), 16'hFF);

        // Single-tick glitch is filtered
        joy1_raw = 8'hFE;
        step(4);
        joy1_raw = 8'hFF;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (joy1_out !== 8'hFF) seen = 1'b1;
        end
        chk("glitch_filtered", 16'(seen), 16'h0);

        // Coin on player 2
        joy2_raw = 8'h6F;
        wait_out(2, 8'h6F, 20, w);
        chk("p2_combo_visible", 16'(joy2_out), 16'h6F);
        wait_coin(2, 60, w);
        chk("p2_arm_lat", 16'(w), 16'd39);
        chk("p2_mask_in_pulse", 16'(joy2_out), 16'hFF);
        chk("p1_coin_idle", 16'(coin1_n), 16'h1);
        pulse_len(2, 40, len);
        chk("p2_pulse_len", 16'(len), 16'd20);
        chk("p2_mask_wait_rel", 16'(joy2_out), 16'hFF);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (coin2_n == 1'b0) seen = 1'b1;
        end
        chk("p2_no_repeat", 16'(seen), 16'h0);
        joy2_raw = 8'hFF;
        step(20);
        chk("p2_released", 16'(joy2_out), 16'hFF);
        joy2_raw = 8'h6F;
        wait_coin(2, 80, w);
        chk("p2_second_coin", 16'(w > 0), 16'h1);
        pulse_len(2, 40, len);
        chk("p2_second_len", 16'(len), 16'd20);
        joy2_raw = 8'hFF;
        step(20);

        // Short combo gives no coin but is visible
        joy1_raw = 8'h6F;
        wait_out(1, 8'h6F, 20, w);
        chk("short_visible", 16'(w > 0), 16'h1);
        step(8);
        chk("short_hold", 16'(joy1_out), 16'h6F);
        joy1_raw = 8'hFF;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (coin1_n == 1'b0) seen = 1'b1;
        end
        chk("short_no_coin", 16'(seen), 16'h0);
        chk("short_out_idle", 16'(joy1_out), 16'hFF);

        // Reset mid-pulse, combo kept held
        joy1_raw = 8'h6F;
        wait_coin(1, 80, w);
        chk("rp_pulse_start", 16'(w > 0), 16'h1);
        step(5);
        chk("rp_in_pulse", 16'(coin1_n), 16'h0);
        reset = 1'b1;
        step(1);
        chk("rp_coin_abort", 16'(coin1_n), 16'h1);
        chk("rp_out_reset", 16'(joy1_out), 16'hFF);
        chk("rp_tick_reset", 16'(tick), 16'h0);
        reset = 1'b0;
        wait_coin(1, 100, w);
        chk("rp_full_rehold", 16'(w), 16'd52);
        pulse_len(1, 40, len);
        chk("rp_pulse_len", 16'(len), 16'd20);
        chk("rp_p2_quiet", 16'(coin2_n), 16'h1);
        joy1_raw = 8'hFF;
        step(20);

        // Opposite directions
        joy1_raw = 8'hFC;
        step(16);
`ifdef JOY_SOCD_EN
        chk("socd_up_down", 16'(joy1_out), 16'hFF);
`else
        chk("socd_up_down", 16'(joy1_out), 16'hFC);
`endif
        joy1_raw = 8'hFF;
        step(20);
        chk("final_idle", 16'({joy1_out, joy2_out}), 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
